// File: rtl/reed_speed_calc.sv
`default_nettype none
// ============================================================================
// Module   : reed_speed_calc
// Function : Reed-switch conditioning (sync + debounce + edge pulse), wheel
//            period measurement and iterative km/h divider with stop timeout.
//            Optional SPEED_AVG_EN: averages each result with the previous one.
// Revision : 1.0  initial release
// ============================================================================
module reed_speed_calc #(
  parameter int CIRC_MM     = 2100,
  parameter int DEB_CYCLES  = 4,
  parameter int STOP_CYCLES = 8192,
  parameter int CNT_W       = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reed_raw,
  output logic       reed,
  output logic [6:0] kmh,
  output logic       kmh_valid,
  output logic       moving
);

  localparam int              C_KNUM_INT = (CIRC_MM * 73728) / 10000;
  // Dividend is split so quotients wider than CNT_W are flagged, not wrapped.
  localparam logic [CNT_W-1:0] C_KNUM_HI = CNT_W'(C_KNUM_INT >> CNT_W);
  localparam logic [CNT_W-1:0] C_KNUM_LO = CNT_W'(C_KNUM_INT);
  localparam int              DEB_W      = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] C_DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] C_STOP     = CNT_W'(STOP_CYCLES);
  localparam logic [CNT_W-1:0] C_KMH_MAX  = CNT_W'(99);
  localparam int              BIT_W      = $clog2(CNT_W);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(CNT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_deb_d;
  logic [DEB_W-1:0] r_stab;
  logic             r_reed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_have_ref;
  state_t           r_state;
  state_t           w_state_next;
  logic [BIT_W-1:0] r_bit;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_quo;
  logic             r_ovf;
  logic [6:0]       r_kmh;
  logic             r_kmh_valid;

  logic             w_timeout;
  logic             w_start;
  logic             w_last;
  logic             w_fire;
  logic [CNT_W-1:0] w_period;
  logic             w_load_ovf;
  logic [CNT_W:0]   w_shift;
  logic [CNT_W:0]   w_diff;
  logic             w_ge;
  logic [CNT_W-1:0] w_rem_next;
  logic [CNT_W-1:0] w_quo_next;
  logic [6:0]       w_new_q;
  logic [6:0]       w_kmh_load;

  // Input conditioning: 2-flop sync, stability-count debounce, rising-edge pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_stab  <= '0;
      r_reed  <= 1'b0;
    end else begin
      r_sync1 <= reed_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_reed  <= r_deb & ~r_deb_d;
      if (r_sync2 == r_deb) begin
        r_stab <= '0;
      end else if (r_stab == C_DEB_LAST) begin
        r_deb  <= r_sync2;
        r_stab <= '0;
      end else begin
        r_stab <= r_stab + 1'b1;
      end
    end
  end

  assign w_timeout  = (r_cnt == C_STOP) && !r_reed;
  assign w_start    = r_reed && r_have_ref;
  assign w_period   = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_load_ovf = (C_KNUM_HI >= w_period);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_have_ref <= 1'b0;
    end else begin
      if (r_reed) begin
        r_cnt <= '0;
      end else if (r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_reed) begin
        r_have_ref <= 1'b1;
      end else if (w_timeout) begin
        r_have_ref <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_last       = (r_state == S_DIV) && (r_bit == C_BIT_LAST);
    w_fire       = w_last && !w_start && !w_timeout;
    if (w_start) begin
      w_state_next = S_DIV;
    end else if (w_timeout) begin
      w_state_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  w_state_next = S_IDLE;
        S_DIV:   w_state_next = w_last ? S_DONE : S_DIV;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Restoring division step: shift in next dividend bit, subtract if it fits
  assign w_shift    = {r_rem, r_quo[CNT_W-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_ge       = ~w_diff[CNT_W];
  assign w_rem_next = w_ge ? w_diff[CNT_W-1:0] : w_shift[CNT_W-1:0];
  assign w_quo_next = {r_quo[CNT_W-2:0], w_ge};
  assign w_new_q    = (r_ovf || (w_quo_next > C_KMH_MAX)) ? 7'd99 : w_quo_next[6:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit <= '0;
      r_div <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_bit <= '0;
      r_div <= w_period;
      r_rem <= w_load_ovf ? '0 : C_KNUM_HI;
      r_quo <= C_KNUM_LO;
      r_ovf <= w_load_ovf;
    end else if (r_state == S_DIV) begin
      r_bit <= r_bit + 1'b1;
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
    end
  end

`ifdef SPEED_AVG_EN
  logic [6:0] r_prev_q;
  logic       r_prev_ok;
  logic [7:0] w_sum;
  logic       w_unused_sum_lsb;

  assign w_sum            = {1'b0, r_prev_q} + {1'b0, w_new_q};
  assign w_unused_sum_lsb = w_sum[0];
  assign w_kmh_load       = r_prev_ok ? w_sum[7:1] : w_new_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_q  <= '0;
      r_prev_ok <= 1'b0;
    end else if (w_timeout) begin
      r_prev_q  <= '0;
      r_prev_ok <= 1'b0;
    end else if (w_fire) begin
      r_prev_q  <= w_new_q;
      r_prev_ok <= 1'b1;
    end
  end
`else
  assign w_kmh_load = w_new_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kmh       <= '0;
      r_kmh_valid <= 1'b0;
    end else if (w_timeout) begin
      r_kmh       <= '0;
      r_kmh_valid <= 1'b1;
    end else if (w_fire) begin
      r_kmh       <= w_kmh_load;
      r_kmh_valid <= 1'b1;
    end else begin
      r_kmh_valid <= 1'b0;
    end
  end

  assign reed      = r_reed;
  assign kmh       = r_kmh;
  assign kmh_valid = r_kmh_valid;
  assign moving    = r_have_ref;

endmodule
`default_nettype wire

// File: tb/tb_reed_speed_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_reed_speed_calc
// Function : Self-checking bench for reed_speed_calc (table of wheel periods,
//            scoreboard of expected reed / kmh_valid events, corner sequences).
// Revision : 1.0  initial release
// ============================================================================
module tb_reed_speed_calc;

  localparam int DEB  = 4;
  localparam int STOP = 8192;
  localparam int LAT  = 15;

  typedef struct {
    int period;
    int exp_kmh;
  } vec_t;

  typedef struct {
    int cyc;
    int kmh;
    bit mov;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       reed_raw;
  logic       reed;
  logic [6:0] kmh;
  logic       kmh_valid;
  logic       moving;

  int   cyc;
  int   n_checks;
  int   n_errors;
  int   reed_q[$];
  ev_t  ev_q[$];
  bit   m_have_ref;
  int   m_next_exp;
  int   m_prev;
  bit   m_prev_ok;
  vec_t vecs[10];

  reed_speed_calc #(
    .CIRC_MM    (2100),
    .DEB_CYCLES (DEB),
    .STOP_CYCLES(STOP),
    .CNT_W      (14)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .reed_raw (reed_raw),
    .reed     (reed),
    .kmh      (kmh),
    .kmh_valid(kmh_valid),
    .moving   (moving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input int n);
    reed_raw = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One wheel rotation: rise now, next rise p cycles later.
  task automatic rotate(input int p, input int exp_q);
    int  r;
    int  hi;
    int  q;
    ev_t e;
    r  = cyc + DEB + 3;
    hi = (p / 2 > 20) ? 20 : p / 2;
    reed_raw = 1'b1;
    reed_q.push_back(r);
    if (m_have_ref) begin
      if (p > LAT - 1) begin
        q = m_next_exp;
`ifdef SPEED_AVG_EN
        if (m_prev_ok) q = (m_prev + m_next_exp) / 2;
        m_prev    = m_next_exp;
        m_prev_ok = 1'b1;
`endif
        e.cyc = r + LAT;
        e.kmh = q;
        e.mov = 1'b1;
        ev_q.push_back(e);
      end
    end else begin
      m_have_ref = 1'b1;
    end
    m_next_exp = exp_q;
    if (p > STOP + 1) begin
      e.cyc = r + STOP + 2;
      e.kmh = 0;
      e.mov = 1'b0;
      ev_q.push_back(e);
      m_have_ref = 1'b0;
      m_prev     = 0;
      m_prev_ok  = 1'b0;
    end
    repeat (hi) @(posedge clk);
    #1 reed_raw = 1'b0;
    repeat (p - hi) @(posedge clk);
    #1;
  endtask

  task automatic check_at_negedge(input string name, input int act_sel, input int exp);
    @(negedge clk);
    case (act_sel)
      0: check(name, int'(kmh), exp);
      1: check(name, int'(moving), exp);
      2: check(name, int'(kmh_valid), exp);
      default: check(name, int'(reed), exp);
    endcase
  endtask

  always @(negedge clk) begin
    int  t;
    ev_t e;
    if (!reset) begin
      while (reed_q.size() > 0 && reed_q[0] < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL reed_missing: got 0, required reed pulse at cycle %0d", reed_q[0]);
        t = reed_q.pop_front();
      end
      if (reed) begin
        n_checks++;
        if (reed_q.size() > 0 && reed_q[0] == cyc) begin
          t = reed_q.pop_front();
        end else begin
          n_errors++;
          $display("FAIL reed_unexpected: got reed=1 at cycle %0d, required 0", cyc);
        end
      end
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL kmh_valid_missing: got 0, required pulse at cycle %0d (kmh %0d)",
                 ev_q[0].cyc, ev_q[0].kmh);
        e = ev_q.pop_front();
      end
      if (kmh_valid) begin
        if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
          e = ev_q.pop_front();
          check("kmh_value", int'(kmh), e.kmh);
          check("moving_at_valid", int'(moving), int'(e.mov));
        end else begin
          n_checks++;
          n_errors++;
          $display("FAIL kmh_valid_unexpected: got pulse at cycle %0d with kmh %0d, required none",
                   cyc, kmh);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{2048, 7};
    vecs[1] = '{1000, 15};
    vecs[2] = '{156, 99};
    vecs[3] = '{100, 99};
    vecs[4] = '{157, 98};
    vecs[5] = '{500, 30};
    vecs[6] = '{777, 19};
    vecs[7] = '{3000, 5};
    vecs[8] = '{8193, 1};
    vecs[9] = '{1000, 15};

    n_checks   = 0;
    n_errors   = 0;
    m_have_ref = 1'b0;
    m_next_exp = 0;
    m_prev     = 0;
    m_prev_ok  = 1'b0;
    reset      = 1'b1;
    reed_raw   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_reed", int'(reed), 0);
    check("reset_kmh", int'(kmh), 0);
    check("reset_kmh_valid", int'(kmh_valid), 0);
    check("reset_moving", int'(moving), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Glitches shorter than the debounce window must not produce a pulse.
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b0, 10);
    check_at_negedge("moving_before_first_reed", 1, 0);
    @(posedge clk);
    #1;
    rotate(2048, 7);
    check_at_negedge("moving_after_arm", 1, 1);
    check_at_negedge("kmh_after_arm", 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      rotate(vecs[i].period, vecs[i].exp_kmh);
    end

    // Stop: timeout after the last reed, then re-arm without output.
    rotate(9000, 0);
    check_at_negedge("kmh_after_timeout", 0, 0);
    check_at_negedge("moving_after_timeout", 1, 0);
    @(posedge clk);
    #1;
    rotate(1000, 15);
    check_at_negedge("moving_after_rearm", 1, 1);
    check_at_negedge("kmh_after_rearm", 0, 0);
    @(posedge clk);
    #1;
    rotate(2048, 7);

    // Two reeds 10 cycles apart: first division is aborted by the second.
    rotate(10, 99);
    rotate(2048, 7);
    rotate(50, 99);

    // Reset during a division: nothing may come out.
    reed_raw = 1'b1;
    reed_q.push_back(cyc + DEB + 3);
    repeat (DEB + 3 + 6) @(posedge clk);
    #1 reset = 1'b1;
    reed_raw   = 1'b0;
    m_have_ref = 1'b0;
    m_prev_ok  = 1'b0;
    m_prev     = 0;
    check_at_negedge("midreset_kmh", 0, 0);
    check_at_negedge("midreset_valid", 2, 0);
    check_at_negedge("midreset_moving", 1, 0);
    check_at_negedge("midreset_reed", 3, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    check_at_negedge("post_reset_kmh", 0, 0);
    check_at_negedge("post_reset_moving", 1, 0);
    check("reed_queue_drained", reed_q.size(), 0);
    check("event_queue_drained", ev_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
